axis_float_operand_joiner: RTL and testbench
============================================

Name: axis_float_operand_joiner

Overview:
- Builds the operand stream consumed by the pipelined single-precision float multiplier.
- Joins two independent 32-bit AXIS float streams (A, B) beat-by-beat into one 64-bit AXIS stream, {A, B}, with A in bits 63:32.
- Generates or forwards the last flag and buffers the output in a 2-entry register FIFO, so ready never passes combinationally from the multiplier back to the sources.
- Sits between the operand sources (DMA/feature readers) and the multiplier's slave port.

Parameters:
- last_mode, "count", "count" = last generated every pkt_len joined beats; "input" = last = s_a_axis_last | s_b_axis_last.
- pkt_len, 16, beats per packet in "count" mode; legal range 1..65535.
- simulation_delay, 1 (real), register update delay for simulation only.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- s_a_axis_data  input  32  operand A float
- s_a_axis_last  input  1  A last
- s_a_axis_valid  input  1  A valid
- s_a_axis_ready  output  1  A ready
- s_b_axis_data  input  32  operand B float
- s_b_axis_last  input  1  B last
- s_b_axis_valid  input  1  B valid
- s_b_axis_ready  output  1  B ready
- m_axis_data  output  64  {A, B}
- m_axis_last  output  1  packet end
- m_axis_valid  output  1  output valid
- m_axis_ready  input  1  downstream ready
- err_last_mismatch  output  1  one-cycle pulse: A/B last flags disagreed on a joined beat ("input" mode only)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FIFO count=0; both entries' data and last=0; beat counter=0.
  - m_axis_valid=0, m_axis_data=0, m_axis_last=0, err_last_mismatch=0.
  - s_a_axis_ready=s_b_axis_ready=0 while rst=1.
  - Reset mid-packet discards buffered beats and restarts the counter at 0.
- space = (count != 2). This is registered state only, with no combinational path from m_axis_ready.
- Join rule:
  - s_a_axis_ready = space & s_b_axis_valid & !rst.
  - s_b_axis_ready = space & s_a_axis_valid & !rst.
  - join_fire = space & both valids. Both inputs transfer on the same edge, or neither does; a lone valid waits indefinitely with no data loss.
- Push on join_fire: entry = {s_a_axis_data, s_b_axis_data}, last tag per mode.
- Pop = m_axis_valid & m_axis_ready.
- FIFO states: EMPTY(0), ONE(1), FULL(2).
  - push only: count+1.
  - pop only: count-1.
  - push & pop in ONE: stays ONE; the new entry becomes head next cycle.
  - push & pop in EMPTY: impossible (valid=0).
  - FULL: no push; pop -> ONE.
- m_axis_valid = (count != 0). m_axis_data and m_axis_last come from the head entry and are held stable while valid & !ready (AXIS rule).
- Latency: join_fire at edge N -> m_axis_valid=1 after edge N.
- Throughput: 1 beat/cycle sustained when m_axis_ready=1.
- "count" mode:
  - 16-bit beat counter increments on join_fire.
  - last tag = (counter == pkt_len-1); counter wraps to 0 on that beat.
  - pkt_len=1 -> every beat has last.
  - Input last flags are ignored; err_last_mismatch stays 0.
- "input" mode:
  - last tag = s_a_axis_last | s_b_axis_last.
  - err_last_mismatch=1 for exactly the cycle after a join_fire where s_a_axis_last != s_b_axis_last.
  - The counter is unused and held at 0.
- No data transformation: float bits pass untouched, so NaN/denormal values are unchanged.

Test Plan:
- Back-to-back: A=0x3F800000.., B=0x40000000.., both valid every cycle, m_axis_ready=1 -> first m_axis_valid one cycle after first join; 1 beat/cycle; m_axis_data=0x3F80000040000000 first; no beat dropped or duplicated over 100 beats.
- Skewed valids: A valid at cycle 0, B valid at cycle 5 -> s_a_axis_ready=0 cycles 0-4; join at cycle 5; A data held unchanged until then.
- Backpressure: m_axis_ready=0 for 10 cycles under continuous input -> exactly 2 beats buffered, s_*_ready=0 after the 2nd join, m_axis_data stable; release -> beats emitted in order, none lost.
- count mode, pkt_len=4, 12 beats -> m_axis_last=1 on beats 4, 8, 12 only. Repeat with pkt_len=1 -> last on every beat.
- input mode: A last on beat 3, B last on beat 4 -> m_axis_last=1 on beats 3 and 4; err_last_mismatch pulses one cycle after each of those joins.
- Reset mid-packet (count mode, pkt_len=8, rst at beat 5 with 2 beats buffered) -> next cycle m_axis_valid=0, readies 0 during rst; after release, last appears on the 8th new beat.

Source files
------------

// File: rtl/axis_float_operand_joiner.sv
`default_nettype none
// ============================================================================
// Module      : axis_float_operand_joiner
// Description : Joins two 32-bit AXIS float streams into one 64-bit {A, B}
//               stream through a 2-entry register FIFO with last generation.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_float_operand_joiner #(
    parameter      last_mode        = "count",
    parameter int  pkt_len          = 16,
    parameter real simulation_delay = 1.0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_a_axis_data,
    input  logic        s_a_axis_last,
    input  logic        s_a_axis_valid,
    output logic        s_a_axis_ready,
    input  logic [31:0] s_b_axis_data,
    input  logic        s_b_axis_last,
    input  logic        s_b_axis_valid,
    output logic        s_b_axis_ready,
    output logic [63:0] m_axis_data,
    output logic        m_axis_last,
    output logic        m_axis_valid,
    input  logic        m_axis_ready,
    output logic        err_last_mismatch
);

    localparam logic [1:0]  c_empty      = 2'd0;
    localparam logic [1:0]  c_one        = 2'd1;
    localparam logic [1:0]  c_full       = 2'd2;
    localparam bit          c_input_mode = (last_mode == "input");
    localparam logic [15:0] c_last_beat  = 16'(pkt_len - 1);

    logic [1:0]  r_count;
    logic [1:0]  w_count_nxt;
    logic [63:0] r_data0;
    logic [63:0] r_data1;
    logic        r_last0;
    logic        r_last1;
    logic [15:0] r_beat;
    logic        r_err;

    logic        w_space;
    logic        w_join;
    logic        w_pop;
    logic        w_beat_last;
    logic        w_tag;
    logic [63:0] w_entry;

    // Readiness depends only on registered occupancy, never on m_axis_ready.
    assign w_space        = (r_count != c_full);
    assign s_a_axis_ready = w_space & s_b_axis_valid & ~rst;
    assign s_b_axis_ready = w_space & s_a_axis_valid & ~rst;
    assign w_join         = w_space & s_a_axis_valid & s_b_axis_valid & ~rst;

    assign m_axis_valid      = (r_count != c_empty);
    assign m_axis_data       = r_data0;
    assign m_axis_last       = r_last0;
    assign err_last_mismatch = r_err;
    assign w_pop             = m_axis_valid & m_axis_ready;

    assign w_beat_last = (r_beat == c_last_beat);
    assign w_tag       = c_input_mode ? (s_a_axis_last | s_b_axis_last) : w_beat_last;
    assign w_entry     = {s_a_axis_data, s_b_axis_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_empty;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case (r_count)
            c_empty: begin
                if (w_join) begin
                    w_count_nxt = c_one;
                end
            end
            c_one: begin
                if (w_join && !w_pop) begin
                    w_count_nxt = c_full;
                end else if (!w_join && w_pop) begin
                    w_count_nxt = c_empty;
                end
            end
            c_full: begin
                if (w_pop) begin
                    w_count_nxt = c_one;
                end
            end
            default: w_count_nxt = c_empty;
        endcase
    end

    // Entry 0 is always the head; entry 1 only holds the second buffered beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0 <= 64'd0;
            r_data1 <= 64'd0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            case (r_count)
                c_empty: begin
                    if (w_join) begin
                        r_data0 <= w_entry;
                        r_last0 <= w_tag;
                    end
                end
                c_one: begin
                    if (w_join && w_pop) begin
                        r_data0 <= w_entry;
                        r_last0 <= w_tag;
                    end else if (w_join) begin
                        r_data1 <= w_entry;
                        r_last1 <= w_tag;
                    end
                end
                c_full: begin
                    if (w_pop) begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || c_input_mode) begin
            r_beat <= 16'd0;
        end else if (w_join) begin
            r_beat <= w_beat_last ? 16'd0 : r_beat + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= c_input_mode & w_join & (s_a_axis_last ^ s_b_axis_last);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_float_operand_joiner.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_float_operand_joiner
// Description : Self-checking bench; four joiner variants share one stimulus
//               and are compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_float_operand_joiner;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_d, b_d;
    logic        a_l, b_l, a_v, b_v, m_rdy;
    logic        a_rdy [4];
    logic        b_rdy [4];
    logic        m_v   [4];
    logic        m_l   [4];
    logic        err   [4];
    logic [63:0] m_d   [4];

    always #5 clk = ~clk;

    // Instances 0..2 count packets of 4, 1 and 8 beats; instance 3 forwards input last.
    for (genvar k = 0; k < 4; k++) begin : g_dut
        axis_float_operand_joiner #(
            .last_mode (k == 3 ? "input" : "count"),
            .pkt_len   (k == 0 ? 4 : (k == 1 ? 1 : (k == 2 ? 8 : 16)))
        ) u_dut (
            .clk               (clk),
            .rst               (rst),
            .s_a_axis_data     (a_d),
            .s_a_axis_last     (a_l),
            .s_a_axis_valid    (a_v),
            .s_a_axis_ready    (a_rdy[k]),
            .s_b_axis_data     (b_d),
            .s_b_axis_last     (b_l),
            .s_b_axis_valid    (b_v),
            .s_b_axis_ready    (b_rdy[k]),
            .m_axis_data       (m_d[k]),
            .m_axis_last       (m_l[k]),
            .m_axis_valid      (m_v[k]),
            .m_axis_ready      (m_rdy),
            .err_last_mismatch (err[k])
        );
    end

    typedef struct {
        logic [63:0] d;
        int          n;
        bit          il;
    } ent_t;

    ent_t q[$];
    int   n_join;
    bit   a_pend, b_pend;
    int   pkt [4] = '{4, 1, 8, 16};
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_v = 1'b1; b_v = 1'b1; m_rdy = 1'b1;
        a_d = $urandom; b_d = $urandom; a_l = 1'b1; b_l = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_a_ready%0d", k), a_rdy[k], 0);
            chk($sformatf("rst_b_ready%0d", k), b_rdy[k], 0);
        end
        @(posedge clk); #1;
        q.delete();
        n_join = 0;
        a_pend = 0;
        b_pend = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_valid%0d", k), m_v[k], 0);
            chk($sformatf("rst_data%0d", k), m_d[k], 0);
            chk($sformatf("rst_last%0d", k), m_l[k], 0);
            chk($sformatf("rst_err%0d", k), err[k], 0);
        end
        rst = 1'b0;
    endtask

    // One clock: sources hold data/last while waiting, then model and DUTs advance together.
    task automatic step(input bit av, input bit bv, input bit rdy,
                        input logic [31:0] ad, input logic [31:0] bd,
                        input bit al, input bit bl);
        bit sp, jf, pp, e_err, exp_last;
        ent_t e;
        if (!a_pend) begin a_v = av; a_d = ad; a_l = al; end
        if (!b_pend) begin b_v = bv; b_d = bd; b_l = bl; end
        m_rdy = rdy;
        #1;
        sp = (q.size() < 2);
        jf = sp && a_v && b_v;
        pp = (q.size() > 0) && rdy;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("a_ready%0d", k), a_rdy[k], sp && b_v);
            chk($sformatf("b_ready%0d", k), b_rdy[k], sp && a_v);
        end
        e_err = jf && (a_l != b_l);
        @(posedge clk); #1;
        if (pp) void'(q.pop_front());
        if (jf) begin
            e.d  = {a_d, b_d};
            e.n  = n_join;
            e.il = a_l | b_l;
            q.push_back(e);
            n_join++;
        end
        a_pend = a_v && !jf;
        b_pend = b_v && !jf;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("valid%0d", k), m_v[k], q.size() > 0);
            chk($sformatf("err%0d", k), err[k], (k == 3) ? e_err : 1'b0);
            if (q.size() > 0) begin
                exp_last = (k == 3) ? q[0].il : ((q[0].n % pkt[k]) == pkt[k] - 1);
                chk($sformatf("data%0d", k), m_d[k], q[0].d);
                chk($sformatf("last%0d", k), m_l[k], exp_last);
            end
        end
    endtask

    initial begin
        do_reset();

        // Back-to-back full-rate stream
        for (int i = 0; i < 100; i++)
            step(1, 1, 1, 32'h3F80_0000 + i, 32'h4000_0000 + i, 0, 0);

        // A waits five cycles for B; A data must be held by the source meanwhile
        for (int i = 0; i < 5; i++)
            step(1, 0, 1, 32'h1111_1111, 32'h0, 0, 0);
        step(1, 1, 1, 32'hDEAD_BEEF, 32'h2222_2222, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 32'h0, 32'h0, 0, 0);

        // Backpressure then release
        for (int i = 0; i < 10; i++)
            step(1, 1, 0, $urandom, $urandom, 0, 0);
        for (int i = 0; i < 6; i++)
            step(1, 1, 1, $urandom, $urandom, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 32'h0, 32'h0, 0, 0);

        // Input-mode last forwarding: A last on beat 3, B last on beat 4
        do_reset();
        for (int j = 1; j <= 6; j++)
            step(1, 1, 1, $urandom, $urandom, j == 3, j == 4);
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 32'h0, 32'h0, 0, 0);

        // Randomised traffic, including NaN/denormal-like raw bit patterns
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                 $urandom, $urandom, ($urandom % 5) == 0, ($urandom % 5) == 0);

        // Reset mid-packet with two beats buffered, then a fresh packet
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1, 1, 1, $urandom, $urandom, 0, 0);
        for (int i = 0; i < 2; i++)
            step(1, 1, 0, $urandom, $urandom, 0, 0);
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1, 1, 1, $urandom, $urandom, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 32'h0, 32'h0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
